// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128/192/256 key expansion: one 32-bit word per clock through a
// shared SubWord, packed into 128-bit round keys on a valid/ready stream.
module aes_key_schedule_seq #(
  parameter int MAX_NK = 8,
  parameter int IDX_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [0:MAX_NK*32-1]  keyin,
  input  logic [1:0]            keylen,
  input  logic                  key_valid,
  output logic                  key_ready,
  output logic [0:127]          rk_data,
  output logic [IDX_W-1:0]      rk_idx,
  output logic                  rk_valid,
  input  logic                  rk_ready,
  output logic                  rk_last,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DRAIN} state_t;

  state_t               state, state_nxt;
  logic [0:MAX_NK*32-1] key_q;
  logic [1:0]           mode_q;
  logic [31:0]          win_p0 [0:MAX_NK-1];
  logic [0:95]          asm_p0;
  logic [5:0]           wcnt;
  logic [2:0]           kmod;
  logic [7:0]           rcon;
  logic                 vld_p1;
  logic                 err_q;

  logic [2:0]           nk_m1;
  logic [5:0]           last_word;
  logic                 accept, fourth, out_free, step, hs;
  logic [31:0]          w_prev, w_old, sub_in, sub_out, word;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as inverse (x^254) followed by the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = gf_mul(x, x);
    inv = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  always_comb begin
    nk_m1     = 3'd7;
    last_word = 6'd59;
    case (mode_q)
      2'd0:    begin nk_m1 = 3'd3; last_word = 6'd43; end
      2'd1:    begin nk_m1 = 3'd5; last_word = 6'd51; end
      default: begin nk_m1 = 3'd7; last_word = 6'd59; end
    endcase
  end

  assign accept   = key_valid && (state == IDLE);
  assign fourth   = (wcnt[1:0] == 2'd3);
  assign out_free = !vld_p1 || rk_ready;
  assign hs       = vld_p1 && rk_ready;
  // The word pipeline only stalls when a finished round key has nowhere to go.
  assign step     = ((state == LOAD) || (state == EXPAND)) && (!fourth || out_free);

  always_comb begin
    w_prev  = win_p0[0];
    w_old   = win_p0[nk_m1];
    sub_in  = (kmod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    sub_out = sub_word(sub_in);
    word    = w_old ^ w_prev;
    if (state == LOAD)
      word = key_q[0:31];
    else if (kmod == 3'd0)
      word = w_old ^ sub_out ^ {rcon, 24'h0};
    else if ((mode_q == 2'd2) && (kmod == 3'd4))
      word = w_old ^ sub_out;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    key_ready = (state == IDLE);
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (accept && (keylen != 2'd3)) state_nxt = LOAD;
      LOAD:    if (step && (kmod == nk_m1)) state_nxt = EXPAND;
      EXPAND:  if (step && (wcnt == last_word)) state_nxt = DRAIN;
      DRAIN:   if (hs && rk_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: key load / expansion window and round assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q  <= '0;
      mode_q <= 2'd0;
      asm_p0 <= '0;
      wcnt   <= 6'd0;
      kmod   <= 3'd0;
      rcon   <= 8'h00;
      err_q  <= 1'b0;
      for (int k = 0; k < MAX_NK; k++) win_p0[k] <= 32'h0;
    end else begin
      err_q <= accept && (keylen == 2'd3);
      if (accept) begin
        key_q  <= keyin;
        mode_q <= keylen;
        asm_p0 <= '0;
        wcnt   <= 6'd0;
        kmod   <= 3'd0;
        rcon   <= 8'h01;
      end else if (step) begin
        for (int k = MAX_NK - 1; k > 0; k--) win_p0[k] <= win_p0[k-1];
        win_p0[0] <= word;
        asm_p0    <= {asm_p0[32:95], word};
        wcnt      <= wcnt + 6'd1;
        kmod      <= (kmod == nk_m1) ? 3'd0 : kmod + 3'd1;
        if (state == LOAD) key_q <= key_q << 32;
        if ((state == EXPAND) && (kmod == 3'd0)) rcon <= xtime(rcon);
      end
    end
  end

  // Stage p1: round-key output register
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      rk_data <= '0;
      rk_idx  <= '0;
      rk_last <= 1'b0;
    end else if (step && fourth) begin
      vld_p1  <= 1'b1;
      rk_data <= {asm_p0, word};
      rk_idx  <= IDX_W'(wcnt[5:2]);
      rk_last <= (wcnt == last_word);
    end else if (hs) begin
      vld_p1  <= 1'b0;
    end
  end

  assign rk_valid = vld_p1;
  assign err      = err_q;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Directed bench for aes_key_schedule_seq using FIPS-197 key expansion vectors.
module tb_aes_key_schedule_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic [0:255] keyin;
  logic [1:0]   keylen;
  logic         key_valid;
  logic         key_ready;
  logic [0:127] rk_data;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic         rk_ready;
  logic         rk_last;
  logic         busy;
  logic         err;

  int tests  = 0;
  int failed = 0;

  logic [127:0] exp128 [0:10];
  logic [255:0] key128, key192, key256;

  always #5 clk = ~clk;

  aes_key_schedule_seq #(.MAX_NK(8), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .keyin(keyin), .keylen(keylen), .key_valid(key_valid),
    .key_ready(key_ready), .rk_data(rk_data), .rk_idx(rk_idx), .rk_valid(rk_valid),
    .rk_ready(rk_ready), .rk_last(rk_last), .busy(busy), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [255:0] k, input logic [1:0] len);
    keyin     = k;
    keylen    = len;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    keyin     = '1;
    keylen    = ~len;
  endtask

  task automatic run128();
    accept(key128, 2'd0);
    chk("load_busy", busy, 1);
    chk("load_key_ready", key_ready, 0);
    repeat (3) tick();
    chk("r0_not_early", rk_valid, 0);
    tick();
    chk("r0_valid", rk_valid, 1);
    chk("r0_data", rk_data, exp128[0]);
    chk("r0_idx", rk_idx, 0);
    chk("r0_last", rk_last, 0);
    for (int r = 1; r <= 10; r++) begin
      repeat (4) tick();
      chk("r128_valid", rk_valid, 1);
      chk("r128_data", rk_data, exp128[r]);
      chk("r128_idx", rk_idx, r);
      chk("r128_last", rk_last, (r == 10));
    end
    tick();
    chk("end128_key_ready", key_ready, 1);
    chk("end128_rk_valid", rk_valid, 0);
    chk("end128_busy", busy, 0);
  endtask

  initial begin
    exp128[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp128[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp128[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp128[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp128[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp128[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp128[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp128[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp128[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp128[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp128[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    key128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    key192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    key256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    rst = 1'b1; keyin = '0; keylen = 2'd0; key_valid = 1'b0; rk_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_key_ready", key_ready, 1);
    chk("rst_rk_valid", rk_valid, 0);
    chk("rst_rk_data", rk_data, 0);
    chk("rst_rk_idx", rk_idx, 0);
    chk("rst_rk_last", rk_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);

    // AES-128, consumer always ready
    run128();

    // AES-192
    accept(key192, 2'd1);
    repeat (4) tick();
    chk("r192_0_valid", rk_valid, 1);
    chk("r192_0_data", rk_data, 128'h8e73b0f7da0e6452c810f32b809079e5);
    for (int r = 1; r <= 12; r++) begin
      repeat (4) tick();
      chk("r192_valid", rk_valid, 1);
      chk("r192_idx", rk_idx, r);
      chk("r192_last", rk_last, (r == 12));
      if (r == 1)  chk("r192_1_data", rk_data, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
      if (r == 12) chk("r192_12_data", rk_data, 128'he98ba06f448c773c8ecc720401002202);
    end
    tick();
    chk("end192_key_ready", key_ready, 1);

    // AES-256, with a stray key_valid while busy that must be ignored
    accept(key256, 2'd2);
    repeat (4) tick();
    chk("r256_0_data", rk_data, 128'h603deb1015ca71be2b73aef0857d7781);
    key_valid = 1'b1; keylen = 2'd0;
    repeat (4) tick();
    key_valid = 1'b0;
    chk("r256_1_data", rk_data, 128'h1f352c073b6108d72d9810a30914dff4);
    repeat (52) tick();
    chk("r256_14_valid", rk_valid, 1);
    chk("r256_14_data", rk_data, 128'hfe4890d1e6188d0b046df344706c631e);
    chk("r256_14_idx", rk_idx, 14);
    chk("r256_14_last", rk_last, 1);
    tick();
    chk("end256_key_ready", key_ready, 1);

    // AES-128 with a ~30% duty consumer
    begin
      int n;
      logic stall;
      logic [127:0] pdata;
      logic [3:0] pidx;
      n = 0; stall = 1'b0; pdata = '0; pidx = '0;
      accept(key128, 2'd0);
      for (int c = 0; c < 3000 && n < 11; c++) begin
        if (stall) begin
          chk("stall_valid", rk_valid, 1);
          chk("stall_data", rk_data, pdata);
          chk("stall_idx", rk_idx, pidx);
        end
        rk_ready = ($urandom_range(0, 99) < 30);
        if (rk_valid && rk_ready) begin
          chk("rand_data", rk_data, exp128[n]);
          chk("rand_idx", rk_idx, n);
          chk("rand_last", rk_last, (n == 10));
          n++;
        end
        stall = rk_valid && !rk_ready;
        pdata = rk_data;
        pidx  = rk_idx;
        tick();
      end
      chk("rand_count", n, 11);
      chk("rand_key_ready", key_ready, 1);
      chk("rand_rk_valid", rk_valid, 0);
      rk_ready = 1'b1;
    end

    // Illegal keylen
    accept(key128, 2'd3);
    chk("ill_err", err, 1);
    chk("ill_key_ready", key_ready, 1);
    chk("ill_rk_valid", rk_valid, 0);
    chk("ill_busy", busy, 0);
    tick();
    chk("ill_err_pulse", err, 0);
    repeat (6) tick();
    chk("ill_no_keys", rk_valid, 0);

    // Reset in the middle of an AES-256 run, then a fresh AES-128 key
    accept(key256, 2'd2);
    repeat (24) tick();
    chk("abort_r5_valid", rk_valid, 1);
    chk("abort_r5_idx", rk_idx, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_key_ready", key_ready, 1);
    chk("abort_rk_valid", rk_valid, 0);
    chk("abort_rk_data", rk_data, 0);
    chk("abort_rk_idx", rk_idx, 0);
    chk("abort_rk_last", rk_last, 0);
    chk("abort_busy", busy, 0);
    chk("abort_err", err, 0);
    run128();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
